// File: rtl/sih_pkg.sv
// sih_pkg: state encodings, header field map and sizing helpers shared by the stream query dispatcher.
package sih_pkg;
  typedef enum logic [3:0] {
    S_HDR  = 4'b0001,
    S_INFO = 4'b0010,
    S_ASM  = 4'b0100,
    S_BLK  = 4'b1000
  } state_e;
  localparam int REF_LEN_LSB  = 0;
  localparam int REF_LEN_W    = 26;
  localparam int REF_ADDR_LSB = 32;
  localparam int REF_ADDR_W   = 26;
  localparam int NQB_LSB      = 64;
  localparam int NQB_W        = 16;
  localparam int QID_LSB      = 80;
  localparam int QID_W        = 16;
  localparam int THR_LSB      = 96;
  localparam int THR_W        = 32;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/query_block_assembler.sv
// query_block_assembler: gathers BEATS stream beats into one 2*NUM_PES-bit block, beat 0 in the LSBs.
module query_block_assembler import sih_pkg::*; #(
  parameter int STREAM_W = 128,
  parameter int NUM_PES  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  beat_i,
  input  logic [STREAM_W-1:0]   data_i,
  output logic [2*NUM_PES-1:0]  block_o,
  output logic                  done_o
);
  localparam int BW    = 2 * NUM_PES;
  localparam int BEATS = ceil_div(BW, STREAM_W);
  localparam int CW    = BEATS > 1 ? clog2(BEATS) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;
  assign last   = cnt_q == CW'(BEATS - 1);
  assign done_o = beat_i & last;
  assign cnt_d  = clr_i || done_o ? '0 : beat_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  // the last slice may be narrower than a beat; its excess beat bits are dropped
  for (genvar k = 0; k < BEATS; k++) begin : g_beat
    localparam int LSB = k * STREAM_W;
    localparam int W   = BW - LSB < STREAM_W ? BW - LSB : STREAM_W;
    logic [W-1:0] slice_q;
    always_ff @(posedge clk)
      if (rst) slice_q <= '0;
      else if (beat_i && cnt_q == CW'(k)) slice_q <= data_i[W-1:0];
    assign block_o[LSB +: W] = slice_q;
  end
endmodule

// File: rtl/stream_query_dispatcher.sv
// stream_query_dispatcher: parses query headers and sequence blocks from one stream and routes each query to engine query_id % NUM_ENGINES.
// Define SIH_STATS_EN to build the stat_queries/stat_blocks counters; otherwise both read 0.
module stream_query_dispatcher import sih_pkg::*; #(
  parameter int STREAM_W    = 128,
  parameter int NUM_PES     = 64,
  parameter int NUM_ENGINES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    si_valid,
  input  logic [STREAM_W-1:0]     si_data,
  output logic                    si_rdy,
  output logic [REF_LEN_W-1:0]    ref_length_out,
  output logic [REF_ADDR_W-1:0]   ref_addr_out,
  output logic [NQB_W-1:0]        num_query_blocks_out,
  output logic [QID_W-1:0]        query_id_out,
  output logic [THR_W-1:0]        cell_score_threshold_out,
  output logic [NUM_ENGINES-1:0]  query_info_valid_out,
  input  logic [NUM_ENGINES-1:0]  query_info_rdy_in,
  output logic [2*NUM_PES-1:0]    query_seq_block_out,
  output logic [NUM_ENGINES-1:0]  query_seq_block_valid_out,
  input  logic [NUM_ENGINES-1:0]  query_seq_block_rdy_in,
  output logic                    busy,
  output logic [31:0]             stat_queries,
  output logic [31:0]             stat_blocks
);
  localparam int ENG_W = clog2(NUM_ENGINES);
  state_e                 state_q, state_d;
  logic [REF_LEN_W-1:0]   ref_len_q;
  logic [REF_ADDR_W-1:0]  ref_addr_q;
  logic [NQB_W-1:0]       nqb_q;
  logic [QID_W-1:0]       qid_q;
  logic [THR_W-1:0]       thr_q;
  logic [ENG_W-1:0]       dst_q;
  logic [15:0]            blk_cnt_q, blk_cnt_d;
  logic                   hdr_acc, beat_acc, info_hs, blk_hs, last_blk, asm_done;
  assign si_rdy   = ~rst & (state_q == S_HDR || state_q == S_ASM);
  assign hdr_acc  = si_valid & si_rdy & (state_q == S_HDR);
  assign beat_acc = si_valid & si_rdy & (state_q == S_ASM);
  assign info_hs  = state_q == S_INFO && query_info_rdy_in[dst_q];
  assign blk_hs   = state_q == S_BLK && query_seq_block_rdy_in[dst_q];
  assign last_blk = blk_cnt_q == nqb_q - 16'd1;
  always_ff @(posedge clk) state_q <= rst ? S_HDR : state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR:   state_d = hdr_acc ? S_INFO : S_HDR;
      S_INFO:  state_d = !info_hs ? S_INFO : nqb_q == '0 ? S_HDR : S_ASM;
      S_ASM:   state_d = asm_done ? S_BLK : S_ASM;
      S_BLK:   state_d = !blk_hs ? S_BLK : last_blk ? S_HDR : S_ASM;
      default: state_d = S_HDR;
    endcase
  end
  always_comb begin
    busy                      = state_q != S_HDR;
    query_info_valid_out      = state_q == S_INFO ? NUM_ENGINES'(1) << dst_q : '0;
    query_seq_block_valid_out = state_q == S_BLK ? NUM_ENGINES'(1) << dst_q : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      ref_len_q  <= '0;
      ref_addr_q <= '0;
      nqb_q      <= '0;
      qid_q      <= '0;
      thr_q      <= '0;
      dst_q      <= '0;
    end else if (hdr_acc) begin
      ref_len_q  <= si_data[REF_LEN_LSB +: REF_LEN_W];
      ref_addr_q <= si_data[REF_ADDR_LSB +: REF_ADDR_W];
      nqb_q      <= si_data[NQB_LSB +: NQB_W];
      qid_q      <= si_data[QID_LSB +: QID_W];
      thr_q      <= si_data[THR_LSB +: THR_W];
      dst_q      <= si_data[QID_LSB +: ENG_W];
    end
  assign ref_length_out           = ref_len_q;
  assign ref_addr_out             = ref_addr_q;
  assign num_query_blocks_out     = nqb_q;
  assign query_id_out             = qid_q;
  assign cell_score_threshold_out = thr_q;
  assign blk_cnt_d = info_hs ? '0 : blk_hs ? blk_cnt_q + 16'd1 : blk_cnt_q;
  always_ff @(posedge clk) blk_cnt_q <= rst ? '0 : blk_cnt_d;
  query_block_assembler #(.STREAM_W(STREAM_W), .NUM_PES(NUM_PES)) u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (info_hs),
    .beat_i  (beat_acc),
    .data_i  (si_data),
    .block_o (query_seq_block_out),
    .done_o  (asm_done)
  );
`ifdef SIH_STATS_EN
  logic [31:0] stat_queries_q, stat_blocks_q;
  logic        query_done;
  assign query_done = (info_hs && nqb_q == '0) || (blk_hs && last_blk);
  always_ff @(posedge clk)
    if (rst) begin
      stat_queries_q <= '0;
      stat_blocks_q  <= '0;
    end else begin
      if (query_done) stat_queries_q <= stat_queries_q + 32'd1;
      if (blk_hs) stat_blocks_q <= stat_blocks_q + 32'd1;
    end
  assign stat_queries = stat_queries_q;
  assign stat_blocks  = stat_blocks_q;
`else
  assign stat_queries = '0;
  assign stat_blocks  = '0;
`endif
endmodule

// File: tb/tb_stream_query_dispatcher.sv
// tb_stream_query_dispatcher: randomized queries against a transaction-level model plus directed corner cases.
// Runs a two-beat block with a partial last beat (STREAM_W=128, NUM_PES=96).
module tb_stream_query_dispatcher;
  localparam int SW    = 128;
  localparam int NP    = 96;
  localparam int NE    = 4;
  localparam int BW    = 2 * NP;
  localparam int BEATS = (BW + SW - 1) / SW;
  typedef struct {
    logic [NE-1:0] oh;
    logic [25:0]   rl;
    logic [25:0]   ra;
    logic [15:0]   nqb;
    logic [15:0]   qid;
    logic [31:0]   thr;
  } info_t;
  typedef struct {
    logic [NE-1:0] oh;
    logic [BW-1:0] data;
    bit            last;
  } blk_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          si_valid = 1'b0;
  logic [SW-1:0] si_data = '0;
  logic          si_rdy;
  logic [25:0]   ref_length_out, ref_addr_out;
  logic [15:0]   num_query_blocks_out, query_id_out;
  logic [31:0]   cell_score_threshold_out;
  logic [NE-1:0] query_info_valid_out, query_seq_block_valid_out;
  logic [NE-1:0] query_info_rdy_in = '0;
  logic [NE-1:0] query_seq_block_rdy_in = '0;
  logic [BW-1:0] query_seq_block_out;
  logic          busy;
  logic [31:0]   stat_queries, stat_blocks;
  info_t         info_q[$];
  blk_t          blk_q[$];
  int            checks = 0;
  int            passes = 0;
  int            m_queries = 0;
  int            m_blocks = 0;
  int            rdy_mode = 1;
  bit            bubbles = 1'b0;
  logic [NE-1:0] cur_oh = '0;
  stream_query_dispatcher #(.STREAM_W(SW), .NUM_PES(NP), .NUM_ENGINES(NE)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .si_valid                  (si_valid),
    .si_data                   (si_data),
    .si_rdy                    (si_rdy),
    .ref_length_out            (ref_length_out),
    .ref_addr_out              (ref_addr_out),
    .num_query_blocks_out      (num_query_blocks_out),
    .query_id_out              (query_id_out),
    .cell_score_threshold_out  (cell_score_threshold_out),
    .query_info_valid_out      (query_info_valid_out),
    .query_info_rdy_in         (query_info_rdy_in),
    .query_seq_block_out       (query_seq_block_out),
    .query_seq_block_valid_out (query_seq_block_valid_out),
    .query_seq_block_rdy_in    (query_seq_block_rdy_in),
    .busy                      (busy),
    .stat_queries              (stat_queries),
    .stat_blocks               (stat_blocks)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic finish_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask
  function automatic logic [NE-1:0] pick();
    return rdy_mode == 0 ? NE'($urandom) : rdy_mode == 2 ? {NE{1'b1}} : '0;
  endfunction
  // Outputs settle after posedge; ready chosen here is what the next posedge sees.
  always @(negedge clk) begin : mon
    logic [NE-1:0] ri, rb;
    ri = pick();
    rb = pick();
    if (!rst) begin
      if (query_info_valid_out != '0 && query_seq_block_valid_out != '0)
        chk("one_valid_kind", {query_info_valid_out, query_seq_block_valid_out}, '0);
      if (query_info_valid_out != '0) begin
        if (info_q.size() == 0) chk("info_unexpected", query_info_valid_out, '0);
        else begin
          chk("info", {query_info_valid_out, ref_length_out, ref_addr_out, num_query_blocks_out,
                       query_id_out, cell_score_threshold_out},
                      {info_q[0].oh, info_q[0].rl, info_q[0].ra, info_q[0].nqb, info_q[0].qid, info_q[0].thr});
          if ((ri & info_q[0].oh) != '0) begin
            if (info_q[0].nqb == 16'd0) m_queries++;
            void'(info_q.pop_front());
          end
        end
      end
      if (query_seq_block_valid_out != '0) begin
        if (blk_q.size() == 0) chk("blk_unexpected", query_seq_block_valid_out, '0);
        else begin
          chk("blk", {query_seq_block_valid_out, query_seq_block_out}, {blk_q[0].oh, blk_q[0].data});
          if ((rb & blk_q[0].oh) != '0) begin
            m_blocks++;
            if (blk_q[0].last) m_queries++;
            void'(blk_q.pop_front());
          end
        end
      end
    end
    query_info_rdy_in      = ri;
    query_seq_block_rdy_in = rb;
  end
  task automatic send_beat(input logic [SW-1:0] d);
    int n;
    n = 0;
    if (bubbles) while ($urandom_range(0, 3) == 0) @(negedge clk);
    si_valid = 1'b1;
    si_data  = d;
    while (!si_rdy) begin
      n++;
      if (n > 400) begin
        chk("si_rdy_timeout", 0, 1);
        finish_run();
      end
      @(negedge clk);
    end
    @(negedge clk);
    si_valid = 1'b0;
    si_data  = {(SW/32){$urandom}};
  endtask
  task automatic send_header(input logic [15:0] qid, input logic [15:0] nqb);
    logic [SW-1:0] h;
    info_t e;
    h = {(SW/32){$urandom}};
    h[95:80] = qid;
    h[79:64] = nqb;
    e.oh  = NE'(1) << (qid % NE);
    e.rl  = h[25:0];
    e.ra  = h[57:32];
    e.nqb = nqb;
    e.qid = qid;
    e.thr = h[127:96];
    info_q.push_back(e);
    cur_oh = e.oh;
    send_beat(h);
    chk("hdr_latency", query_info_valid_out, e.oh);
  endtask
  task automatic send_block(input logic [SW-1:0] beats [BEATS], input bit last);
    logic [BEATS*SW-1:0] full;
    blk_t e;
    for (int k = 0; k < BEATS; k++) full[k*SW +: SW] = beats[k];
    e.oh   = cur_oh;
    e.data = full[BW-1:0];
    e.last = last;
    blk_q.push_back(e);
    for (int k = 0; k < BEATS; k++) begin
      send_beat(beats[k]);
      if (k == BEATS - 1) chk("blk_latency", query_seq_block_valid_out, cur_oh);
      else chk("no_early_blk", query_seq_block_valid_out, '0);
    end
  endtask
  task automatic run_query(input logic [15:0] qid, input logic [15:0] nqb);
    logic [SW-1:0] b [BEATS];
    send_header(qid, nqb);
    for (int i = 0; i < int'(nqb); i++) begin
      for (int k = 0; k < BEATS; k++) b[k] = {(SW/32){$urandom}};
      send_block(b, i == int'(nqb) - 1);
    end
  endtask
  initial begin
    logic [SW-1:0] ab [BEATS];
    logic [BW-1:0] ab_exp;
    int n;
    ab[0]  = 128'h00112233445566778899aabbccddeeff;
    ab[1]  = 128'hdeadbeefcafef00d0123456789abcdef;
    ab_exp = 192'h0123456789abcdef00112233445566778899aabbccddeeff;
    repeat (3) @(negedge clk);
    chk("rst_si_rdy", si_rdy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_si_rdy", si_rdy, 1'b1);
    chk("idle_state", {busy, query_info_valid_out, query_seq_block_valid_out}, '0);
    chk("idle_stats", {stat_queries, stat_blocks}, '0);
    // qid=5 -> engine 1; hold both handshakes off for 10 cycles
    send_header(16'd5, 16'd2);
    chk("qid5_onehot", query_info_valid_out, 4'b0010);
    repeat (10) begin
      @(negedge clk);
      chk("info_hold", {si_rdy, query_info_valid_out, query_id_out, num_query_blocks_out},
                       {1'b0, 4'b0010, 16'd5, 16'd2});
    end
    rdy_mode = 2;
    repeat (3) @(negedge clk);
    rdy_mode = 1;
    send_block(ab, 1'b0);
    chk("blk_ab_literal", query_seq_block_out, ab_exp);
    repeat (10) begin
      @(negedge clk);
      chk("blk_hold", {si_rdy, query_seq_block_valid_out, query_seq_block_out}, {1'b0, 4'b0010, ab_exp});
    end
    rdy_mode = 2;
    for (int k = 0; k < BEATS; k++) ab[k] = {(SW/32){$urandom}};
    send_block(ab, 1'b1);
    send_header(16'd8, 16'd0);
    chk("nqb0_onehot", query_info_valid_out, 4'b0001);
    @(negedge clk);
    chk("nqb0_idle", {busy, si_rdy, query_info_valid_out, query_seq_block_valid_out}, {1'b0, 1'b1, 8'h00});
    // reset in the middle of block assembly
    send_header(16'd2, 16'd2);
    send_beat({(SW/32){$urandom}});
    chk("mid_asm_busy", {busy, query_seq_block_valid_out}, {1'b1, 4'b0000});
    rst = 1'b1;
    info_q.delete();
    blk_q.delete();
    m_queries = 0;
    m_blocks  = 0;
    @(negedge clk);
    chk("rst_mid_si_rdy", si_rdy, 1'b0);
    @(negedge clk);
    chk("rst_mid_state", {busy, query_info_valid_out, query_seq_block_valid_out, stat_queries, stat_blocks}, '0);
    rst = 1'b0;
    @(negedge clk);
    run_query(16'd3, 16'd1);
    // randomized traffic with random engine readiness and stream bubbles
    rdy_mode = 0;
    bubbles  = 1'b1;
    for (int q = 0; q < 25; q++) run_query(16'($urandom), 16'($urandom_range(0, 4)));
    rdy_mode = 2;
    n = 0;
    while ((info_q.size() != 0 || blk_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", {info_q.size(), blk_q.size()}, '0);
    repeat (2) @(negedge clk);
    chk("final_idle", {busy, si_rdy}, {1'b0, 1'b1});
`ifdef SIH_STATS_EN
    chk("stat_queries", stat_queries, 32'(m_queries));
    chk("stat_blocks", stat_blocks, 32'(m_blocks));
`else
    chk("stat_queries_off", stat_queries, 32'd0);
    chk("stat_blocks_off", stat_blocks, 32'd0);
`endif
    finish_run();
  end
endmodule
